io_output: RTL and testbench

- Memory-mapped output-port block: the write-side counterpart of the input-port block in the I/O address window (addr[7] = 1).
- CPU store data addressed to output ports is captured into registers on io_clk, and a one-cycle write strobe is raised per port.
- Includes a time-multiplexed 8-digit seven-segment scanner that displays a CPU-selectable port in hex. Sits beside data memory in the top-level computer, driven by the same addr/datain/write-enable bus.

---
 rtl/io_pkg.sv | 45 ++++
 rtl/io_seg7_scan.sv | 61 ++++++
 rtl/io_output.sv | 104 ++++++++++
 tb/tb_io_output.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared I/O-window definitions: address selects, display control layout and
// the hex-to-seven-segment glyph table.
package io_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = 6;
    localparam int unsigned NPORTS  = 3;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned NIBBLE_W = 4;

    // Input-side selects (read path), same window as the output ports
    localparam logic [SEL_W-1:0] SEL_IN0  = 6'b100000;
    localparam logic [SEL_W-1:0] SEL_IN1  = 6'b100001;
    localparam logic [SEL_W-1:0] SEL_IN2  = 6'b100010;

    localparam logic [SEL_W-1:0] SEL_OUT0 = 6'b100000;
    localparam logic [SEL_W-1:0] SEL_OUT1 = 6'b100001;
    localparam logic [SEL_W-1:0] SEL_OUT2 = 6'b100010;
    localparam logic [SEL_W-1:0] SEL_DCTL = 6'b100011;

    typedef enum logic [1:0] {
        SRC_PORT0 = 2'd0,
        SRC_PORT1 = 2'd1,
        SRC_PORT2 = 2'd2,
        SRC_BLANK = 2'd3
    } disp_src_e;

    typedef struct packed {
        disp_src_e src;
        logic      en;
    } dctl_t;

    localparam int unsigned DCTL_W = $bits(dctl_t);

    // Active-low {dp,g,f,e,d,c,b,a}; entry n lives at bits [8n+7:8n], dp always off
    localparam logic [16*SEG_W-1:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nib);
        return SEG_HEX[{nib, 3'b000} +: SEG_W];
    endfunction

endpackage

// File: rtl/io_seg7_scan.sv
// Time-multiplexed 8-digit seven-segment scanner showing a 32-bit value in hex.
module io_seg7_scan
    import io_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              io_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] value_i,
    input  logic              enable_i,
    output logic [SEG_W-1:0]  seg_an_o,
    output logic [SEG_W-1:0]  seg_cat_o
);

    localparam int unsigned PRE_W = 20;
    localparam int unsigned IDX_W = 3;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SEG_W-1:0] an_q, an_d;
    logic [SEG_W-1:0] cat_q, cat_d;

    // Prescaler wraps at SCAN_DIV-1 and steps the digit index
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // Drive the digit selected before this edge's index step
    always_comb begin
        an_d  = '1;
        cat_d = '1;
        if (enable_i) begin
            an_d  = ~(SEG_W'(1) << idx_q);
            cat_d = hex_to_seg(value_i[{idx_q, 2'b00} +: NIBBLE_W]);
        end
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            cat_q <= '1;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            cat_q <= cat_d;
        end
    end

    assign seg_an_o  = an_q;
    assign seg_cat_o = cat_q;

endmodule

// File: rtl/io_output.sv
// Memory-mapped output ports with per-port write strobes, display control
// register and a seven-segment scanner showing the selected port.
module io_output
    import io_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              io_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] datain,
    input  logic              write_io_enable,
    output logic [DATA_W-1:0] out_port0,
    output logic [DATA_W-1:0] out_port1,
    output logic [DATA_W-1:0] out_port2,
    output logic [NPORTS-1:0] out_wr,
    output logic [SEG_W-1:0]  seg_an,
    output logic [SEG_W-1:0]  seg_cat
);

    logic [SEL_W-1:0]  sel;
    logic [NPORTS-1:0] port_hit_c;
    logic              dctl_hit_c;

    logic [DATA_W-1:0] port0_q, port0_d;
    logic [DATA_W-1:0] port1_q, port1_d;
    logic [DATA_W-1:0] port2_q, port2_d;
    logic [NPORTS-1:0] wr_q, wr_d;
    dctl_t             dctl_q, dctl_d;

    logic [DATA_W-1:0] disp_val_c;
    logic              disp_en_c;
    logic              unused_addr_bits;

    assign sel              = addr[7:2];
    assign unused_addr_bits = ^{addr[DATA_W-1:8], addr[1:0]};

    always_comb begin
        port_hit_c = '0;
        dctl_hit_c = 1'b0;
        if (write_io_enable) begin
            case (sel)
                SEL_OUT0: port_hit_c[0] = 1'b1;
                SEL_OUT1: port_hit_c[1] = 1'b1;
                SEL_OUT2: port_hit_c[2] = 1'b1;
                SEL_DCTL: dctl_hit_c    = 1'b1;
                default:  ;
            endcase
        end
    end

    // Only the low DCTL bits are stored; the rest read back as zero by construction
    always_comb begin
        port0_d = port_hit_c[0] ? datain : port0_q;
        port1_d = port_hit_c[1] ? datain : port1_q;
        port2_d = port_hit_c[2] ? datain : port2_q;
        wr_d    = port_hit_c;
        dctl_d  = dctl_hit_c ? dctl_t'(datain[DCTL_W-1:0]) : dctl_q;
    end

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            port0_q <= '0;
            port1_q <= '0;
            port2_q <= '0;
            wr_q    <= '0;
            dctl_q  <= '0;
        end else begin
            port0_q <= port0_d;
            port1_q <= port1_d;
            port2_q <= port2_d;
            wr_q    <= wr_d;
            dctl_q  <= dctl_d;
        end
    end

    always_comb begin
        disp_val_c = '0;
        disp_en_c  = dctl_q.en && (dctl_q.src != SRC_BLANK);
        case (dctl_q.src)
            SRC_PORT0: disp_val_c = port0_q;
            SRC_PORT1: disp_val_c = port1_q;
            SRC_PORT2: disp_val_c = port2_q;
            default:   disp_val_c = '0;
        endcase
    end

    io_seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .io_clk    (io_clk),
        .reset     (reset),
        .value_i   (disp_val_c),
        .enable_i  (disp_en_c),
        .seg_an_o  (seg_an),
        .seg_cat_o (seg_cat)
    );

    assign out_port0 = port0_q;
    assign out_port1 = port1_q;
    assign out_port2 = port2_q;
    assign out_wr    = wr_q;

endmodule

// File: tb/tb_io_output.sv
// Directed bench for io_output: a reference model queues the expected
// post-edge state per driven cycle, compared after each edge.
module tb_io_output;

    localparam int unsigned DIV = 4;

    logic        io_clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [31:0] out_port0, out_port1, out_port2;
    logic [2:0]  out_wr;
    logic [7:0]  seg_an, seg_cat;

    io_output #(.SCAN_DIV(DIV)) dut (
        .io_clk          (io_clk),
        .reset           (reset),
        .addr            (addr),
        .datain          (datain),
        .write_io_enable (write_io_enable),
        .out_port0       (out_port0),
        .out_port1       (out_port1),
        .out_port2       (out_port2),
        .out_wr          (out_wr),
        .seg_an          (seg_an),
        .seg_cat         (seg_cat)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    typedef struct {
        logic [31:0] p0, p1, p2;
        logic [2:0]  wr;
        logic [7:0]  an, cat;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_p0, m_p1, m_p2;
    logic [2:0]  m_dctl;
    int          m_pre, m_idx;

    function automatic logic [7:0] tb_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic m_reset();
        m_p0 = '0; m_p1 = '0; m_p2 = '0;
        m_dctl = '0; m_pre = 0; m_idx = 0;
    endtask

    // Drive one bus cycle, push the expected result, then compare after the edge
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we);
        exp_t        e;
        exp_t        r;
        logic [31:0] src;
        logic [7:0]  one;
        addr = a; datain = d; write_io_enable = we;
        src = (m_dctl[2:1] == 2'd0) ? m_p0 : (m_dctl[2:1] == 2'd1) ? m_p1 : m_p2;
        if (m_dctl[0] && m_dctl[2:1] != 2'd3) begin
            one   = 8'd1 << m_idx;
            e.an  = ~one;
            e.cat = tb_glyph(src[m_idx*4 +: 4]);
        end else begin
            e.an  = 8'hFF;
            e.cat = 8'hFF;
        end
        e.wr = 3'b000;
        if (we) begin
            case (a[7:2])
                6'b100000: begin m_p0 = d; e.wr = 3'b001; end
                6'b100001: begin m_p1 = d; e.wr = 3'b010; end
                6'b100010: begin m_p2 = d; e.wr = 3'b100; end
                6'b100011: m_dctl = d[2:0];
                default: ;
            endcase
        end
        e.p0 = m_p0; e.p1 = m_p1; e.p2 = m_p2;
        if (m_pre == DIV - 1) begin
            m_pre = 0;
            m_idx = (m_idx + 1) % 8;
        end else begin
            m_pre = m_pre + 1;
        end
        sb.push_back(e);
        @(posedge io_clk);
        #1;
        r = sb.pop_front();
        chk("out_port0", out_port0, r.p0);
        chk("out_port1", out_port1, r.p1);
        chk("out_port2", out_port2, r.p2);
        chk("out_wr",    {29'd0, out_wr}, {29'd0, r.wr});
        chk("seg_an",    {24'd0, seg_an}, {24'd0, r.an});
        chk("seg_cat",   {24'd0, seg_cat}, {24'd0, r.cat});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; addr = '0; datain = '0; write_io_enable = 1'b0;
        m_reset();
        #1 reset = 1'b1;
        #1;
        chk("rst_port0", out_port0, 32'h0);
        chk("rst_port1", out_port1, 32'h0);
        chk("rst_port2", out_port2, 32'h0);
        chk("rst_wr",    {29'd0, out_wr}, 32'h0);
        chk("rst_an",    {24'd0, seg_an}, 32'hFF);
        chk("rst_cat",   {24'd0, seg_cat}, 32'hFF);
        @(posedge io_clk);
        #1 reset = 1'b0;

        step(32'h80, 32'h12345678, 1'b1);
        idle(1);
        step(32'h84, 32'hDEADBEEF, 1'b0);
        step(32'h90, 32'hDEADBEEF, 1'b1);
        idle(1);

        // Scan port0 through more than one full digit rotation
        step(32'h8C, 32'h1, 1'b1);
        idle(36);

        step(32'h8C, 32'h7, 1'b1);
        idle(5);
        step(32'h88, 32'h1, 1'b1);
        step(32'h88, 32'h2, 1'b1);
        idle(1);
        step(32'h8C, 32'h5, 1'b1);
        idle(6);
        step(32'h88, 32'hFEDCBA90, 1'b1);
        idle(10);
        step(32'h84, 32'h0BADF00D, 1'b1);
        step(32'h8C, 32'hFFFFFFFB, 1'b1);
        idle(12);
        step(32'h8C, 32'hFFFFFFF8, 1'b1);
        idle(3);
        step(32'h8C, 32'h1, 1'b1);
        idle(5);

        // Reset between edges with a concurrent write
        #2;
        reset = 1'b1; addr = 32'h80; datain = 32'hA5A5A5A5; write_io_enable = 1'b1;
        #1;
        chk("arst_port0", out_port0, 32'h0);
        chk("arst_port1", out_port1, 32'h0);
        chk("arst_port2", out_port2, 32'h0);
        chk("arst_wr",    {29'd0, out_wr}, 32'h0);
        chk("arst_an",    {24'd0, seg_an}, 32'hFF);
        chk("arst_cat",   {24'd0, seg_cat}, 32'hFF);
        @(posedge io_clk);
        #1;
        chk("arst_wr_drop", out_port0, 32'h0);
        chk("arst_wr_strobe", {29'd0, out_wr}, 32'h0);
        write_io_enable = 1'b0;
        reset = 1'b0;
        m_reset();

        step(32'h80, 32'h9ABCDEF0, 1'b1);
        step(32'h8C, 32'h1, 1'b1);
        idle(34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
